// File: rtl/aes_v1_subword_par.sv
// AES SubWord unit: forward/inverse SBox over all four bytes of a latched
// 32-bit operand, NSBOX bytes per step, with optional RotWord on the result.

module aes_sbox (
    input  logic [7:0] in_byte,
    input  logic       dec,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a14, a15, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a14  = gf_mul(a12, a2);
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        return gf_mul(a240, a14);
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] b);
        logic [7:0] o;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            o[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return o;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] b);
        logic [7:0] o;
        logic [7:0] c;
        c = 8'h05;
        for (int i = 0; i < 8; i++)
            o[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return o;
    endfunction

    logic [7:0] inv_in;
    logic [7:0] inv_out;

    always_comb begin
        inv_in   = dec ? affine_inv(in_byte) : in_byte;
        inv_out  = gf_inv(inv_in);
        out_byte = dec ? inv_out : affine_fwd(inv_out);
    end

endmodule

module aes_v1_subword_par #(
    parameter int NSBOX = 1
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        valid,
    input  logic        dec,
    input  logic        rot,
    input  logic [31:0] rs1,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rd
);

    localparam int STEPS = 4 / NSBOX;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4)) begin : g_bad_nsbox
            $error("aes_v1_subword_par: NSBOX must be 1, 2 or 4");
        end
    endgenerate

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [SW-1:0] step;
    logic [31:0]   op;
    logic [31:0]   res;
    logic          dec_q;
    logic          rot_q;
    logic          accept;
    logic          last_step;
    logic [7:0]    sb_in  [NSBOX];
    logic [7:0]    sb_out [NSBOX];

    assign accept    = valid && (state == S_IDLE || state == S_DONE);
    assign last_step = (step == SW'(STEPS - 1));

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = valid ? S_RUN : S_IDLE;
            S_RUN:   state_nxt = last_step ? S_DONE : S_RUN;
            S_DONE:  state_nxt = valid ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Each step feeds byte lanes step*NSBOX .. step*NSBOX+NSBOX-1 to the SBoxes.
    for (genvar j = 0; j < NSBOX; j++) begin : g_lane
        always_comb sb_in[j] = op[((int'(step) % STEPS) * NSBOX + j) * 8 +: 8];

        aes_sbox u_sbox (
            .in_byte  (sb_in[j]),
            .dec      (dec_q),
            .out_byte (sb_out[j])
        );
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state <= S_IDLE;
            step  <= '0;
            op    <= '0;
            res   <= '0;
            dec_q <= 1'b0;
            rot_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op    <= rs1;
                dec_q <= dec;
                rot_q <= rot;
                step  <= '0;
            end else if (state == S_RUN) begin
                step <= step + SW'(1);
                for (int j = 0; j < NSBOX; j++)
                    res[((int'(step) % STEPS) * NSBOX + j) * 8 +: 8] <= sb_out[j];
            end
        end
    end

    assign busy  = (state == S_RUN);
    assign ready = (state == S_DONE);
    assign rd    = rot_q ? {res[23:0], res[31:24]} : res;

endmodule

// File: tb/tb_aes_v1_subword_par.sv
// Bench for aes_v1_subword_par: exercises NSBOX = 1, 2, 4 side by side against
// a GF(2^8) reference model built from first principles.

module tb_aes_v1_subword_par;

    logic        clk;
    logic        g_resetn;
    logic        valid_v [3];
    logic        dec_v   [3];
    logic        rot_v   [3];
    logic [31:0] rs1_v   [3];
    logic        busy_v  [3];
    logic        ready_v [3];
    logic [31:0] rd_v    [3];

    int checks;
    int errors;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_v1_subword_par #(.NSBOX((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
            .g_clk    (clk),
            .g_resetn (g_resetn),
            .valid    (valid_v[g]),
            .dec      (dec_v[g]),
            .rot      (rot_v[g]),
            .rs1      (rs1_v[g]),
            .busy     (busy_v[g]),
            .ready    (ready_v[g]),
            .rd       (rd_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int steps_of(input int k);
        return 4 / ((k == 0) ? 1 : (k == 1) ? 2 : 4);
    endfunction

    // Schoolbook polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] poly_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] a, input logic d, input logic r);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[i*8 +: 8] = d ? inv_tab[a[i*8 +: 8]] : fwd_tab[a[i*8 +: 8]];
        return r ? {w[23:0], w[31:24]} : w;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input int k, input logic [31:0] a, input logic d, input logic r);
        valid_v[k] = 1'b1;
        rs1_v[k]   = a;
        dec_v[k]   = d;
        rot_v[k]   = r;
    endtask

    // Accept edge, scramble inputs, then watch for the ready pulse; returns at the ready negedge.
    task automatic wait_done(input int k, input logic [31:0] exp, input bit poke, input string tag);
        int n;
        bit seen;
        @(posedge clk);
        #1;
        valid_v[k] = 1'b0;
        rs1_v[k]   = $urandom;
        dec_v[k]   = 1'($urandom);
        rot_v[k]   = 1'($urandom);
        seen = 1'b0;
        n = 0;
        while (!seen && n < 12) begin
            n++;
            @(negedge clk);
            if (ready_v[k]) begin
                seen = 1'b1;
                check({tag, "_latency"}, 32'(n), 32'(steps_of(k) + 1));
                check({tag, "_rd"}, rd_v[k], exp);
                check({tag, "_busy_done"}, 32'(busy_v[k]), 32'd0);
            end else begin
                check({tag, "_busy_run"}, 32'(busy_v[k]), 32'd1);
            end
            valid_v[k] = poke && n == 1;
            if (poke && n == 1) rs1_v[k] = 32'hFFFF_FFFF;
        end
        valid_v[k] = 1'b0;
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic idle_check(input int k, input logic [31:0] exp, input string tag);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(ready_v[k]), 32'd0);
        check({tag, "_hold"}, rd_v[k], exp);
        check({tag, "_idle_busy"}, 32'(busy_v[k]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic        d;
        logic        r;
        logic [7:0]  inv;
        int          pulses;

        checks = 0;
        errors = 0;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (poly_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            fwd_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        for (int k = 0; k < 3; k++) begin
            valid_v[k] = 1'b0;
            dec_v[k]   = 1'b0;
            rot_v[k]   = 1'b0;
            rs1_v[k]   = '0;
        end
        g_resetn = 1'b0;
        repeat (2) @(negedge clk);
        g_resetn = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d_busy", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("reset%0d_ready", k), 32'(ready_v[k]), 32'd0);
            check($sformatf("reset%0d_rd", k), rd_v[k], 32'h0000_0000);
        end

        for (int k = 0; k < 3; k++) begin
            start(k, 32'h0000_0000, 1'b0, 1'b0);
            wait_done(k, 32'h6363_6363, 1'b0, $sformatf("zero%0d", k));
            idle_check(k, 32'h6363_6363, $sformatf("zero%0d", k));

            start(k, 32'h0000_0153, 1'b0, 1'b0);
            wait_done(k, 32'h6363_7CED, 1'b0, $sformatf("fwd%0d", k));
            idle_check(k, 32'h6363_7CED, $sformatf("fwd%0d", k));

            start(k, 32'h0000_0153, 1'b0, 1'b1);
            wait_done(k, 32'h637C_ED63, 1'b0, $sformatf("rot%0d", k));
            idle_check(k, 32'h637C_ED63, $sformatf("rot%0d", k));

            start(k, 32'h637C_ED63, 1'b1, 1'b0);
            wait_done(k, 32'h0001_5300, 1'b0, $sformatf("inv%0d", k));
            start(k, 32'h0000_0000, 1'b0, 1'b0);
            wait_done(k, 32'h6363_6363, 1'b0, $sformatf("b2b%0d", k));
            idle_check(k, 32'h6363_6363, $sformatf("b2b%0d", k));

            start(k, 32'h1234_5678, 1'b0, 1'b0);
            wait_done(k, sub_word(32'h1234_5678, 1'b0, 1'b0), 1'b1, $sformatf("poke%0d", k));
            idle_check(k, sub_word(32'h1234_5678, 1'b0, 1'b0), $sformatf("poke%0d", k));

            for (int i = 0; i < 8; i++) begin
                a = $urandom;
                d = 1'($urandom);
                r = 1'($urandom);
                start(k, a, d, r);
                wait_done(k, sub_word(a, d, r), 1'b0, $sformatf("rand%0d_%0d", k, i));
            end
            idle_check(k, sub_word(a, d, r), $sformatf("rand%0d", k));

            start(k, 32'hA5A5_A5A5, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            valid_v[k] = 1'b0;
            if (steps_of(k) > 1) begin
                @(posedge clk);
                #2;
            end else begin
                @(negedge clk);
            end
            g_resetn = 1'b0;
            #1;
            check($sformatf("abort%0d_busy", k), 32'(busy_v[k]), 32'd0);
            check($sformatf("abort%0d_ready", k), 32'(ready_v[k]), 32'd0);
            check($sformatf("abort%0d_rd", k), rd_v[k], 32'h0000_0000);
            repeat (2) @(negedge clk);
            g_resetn = 1'b1;
            pulses = 0;
            repeat (6) begin
                @(negedge clk);
                if (ready_v[k]) pulses++;
            end
            check($sformatf("abort%0d_no_ready", k), 32'(pulses), 32'd0);
            check($sformatf("abort%0d_rd_after", k), rd_v[k], 32'h0000_0000);

            start(k, 32'h0000_0153, 1'b0, 1'b1);
            wait_done(k, 32'h637C_ED63, 1'b0, $sformatf("recover%0d", k));
            idle_check(k, 32'h637C_ED63, $sformatf("recover%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
